// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRisc multicycle control unit: opcodes, FSM states,
// ALU operation selects and PC source selects.
package nrisc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB     = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    // Opcodes B..E are unassigned and stop the core.
    function automatic state_t decode_next(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: decode_next = S_EXEC_R;
            OP_ADDI, OP_LW, OP_SW:                 decode_next = S_EXEC_I;
            OP_BEQ, OP_BNE:                        decode_next = S_BRANCH;
            OP_JMP:                                decode_next = S_JUMP;
            default:                               decode_next = S_HALT;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        is_legal = (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/nrisc_wait_timer.sv
// Memory wait counter: counts enabled cycles, saturates at LIMIT and flags expiry.
module nrisc_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CW'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/nrisc_mc_ctrl.sv
// Multicycle control FSM for nRisc, including branch resolution into pc_write/pc_src.
// Optional NRISC_MEM_TIMEOUT_EN bounds memory waits and halts with mem_timeout set.
module nrisc_mc_ctrl
    import nrisc_pkg::*;
#(
    parameter int OPCODE_W       = 4,
    parameter int ALUOP_W        = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zeroULA,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                halted,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [3:0]          dbg_state_o
);
    // Memory handshake: mem_req stays high in a wait state until the cycle in
    // which mem_ack is seen (possibly the first one); that cycle completes the
    // access and the FSM moves on at the next edge. mem_ack elsewhere is ignored.
    state_t     state_q, state_d;
    logic       wb_mem_q;
    logic       illegal_q;
    logic       expired;
    logic       ack_ok;
    logic [3:0] op4;

    assign op4    = opcode[3:0];
    assign ack_ok = mem_ack & ~expired;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS1;
        alu_op     = '0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = ~expired;
                if (expired) begin
                    state_d = S_HALT;
                end else if (ack_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = decode_next(op4);
            S_EXEC_R: begin
                // R-type opcodes 0..4 coincide with the ALU select codes.
                alu_op  = ALUOP_W'(op4[2:0]);
                state_d = S_WB;
            end
            S_EXEC_I: begin
                alu_op  = ALUOP_W'(ALU_ADD);
                alu_src = 1'b1;
                if (op4 == OP_LW)      state_d = S_MEM_RD;
                else if (op4 == OP_SW) state_d = S_MEM_WR;
                else                   state_d = S_WB;
            end
            S_MEM_RD: begin
                mem_req = ~expired;
                if (expired)     state_d = S_HALT;
                else if (ack_ok) state_d = S_WB;
            end
            S_MEM_WR: begin
                mem_req = ~expired;
                mem_we  = ~expired;
                if (expired)     state_d = S_HALT;
                else if (ack_ok) state_d = S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = wb_mem_q;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALUOP_W'(ALU_SUB);
                pc_src   = PC_BRANCH;
                pc_write = (op4 == OP_BNE) ? ~zeroULA : zeroULA;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                state_d  = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_HALT;
        endcase
        // The state register resets to FETCH, so its strobes are masked while reset is held.
        if (!reset_n) begin
            mem_req  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            pc_src   = PC_PLUS1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            wb_mem_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_mem_q <= (state_q == S_MEM_RD) && (state_d == S_WB);
            if ((state_q == S_DECODE) && !is_legal(op4)) illegal_q <= 1'b1;
        end
    end

    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

`ifdef NRISC_MEM_TIMEOUT_EN
    logic mem_timeout_q;

    nrisc_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (state_d != state_q),
        .en_i     (mem_req & ~mem_ack),
        .expired_o(expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     mem_timeout_q <= 1'b0;
        else if (expired) mem_timeout_q <= 1'b1;
    end

    assign mem_timeout = mem_timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
    assign mem_timeout    = 1'b0;
`endif

endmodule
